// File: rtl/cpu_wb_pkg.sv
// Shared select encodings and writeback FSM state type for the execute-stage result path.
package cpu_wb_pkg;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_ALU1 = 3'b001;
    localparam logic [2:0] SEL_ALU2 = 3'b010;
    localparam logic [2:0] SEL_ALU3 = 3'b011;
    localparam logic [2:0] SEL_MUL  = 3'b100;
    localparam logic [2:0] SEL_ALU5 = 3'b101;
    localparam logic [2:0] SEL_RES2 = 3'b110;
    localparam logic [2:0] SEL_ILL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        WB_LO,
        WB_HI
    } wb_state_t;

endpackage

// File: rtl/mul_timeout_cnt.sv
// Multiplier wait counter: loads 1 on start, increments per waiting cycle,
// and flags (registered) when the count has reached the timeout limit.
module mul_timeout_cnt #(
    parameter int unsigned MUL_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam int unsigned CNT_W = $clog2(MUL_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Limit flag tracks the next count so it lines up with cnt_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= (cnt_d == CNT_W'(MUL_TIMEOUT));
        end
    end

    assign at_limit_o = at_limit_q;

endmodule

// File: rtl/writeback_ctrl_24b.sv
// Sequences ALU, third-source and two-half multiply results onto the single
// register-file write port; stalls issue while a multiply is in flight.
module writeback_ctrl_24b
    import cpu_wb_pkg::*;
#(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MUL_TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [2:0]              sel_i,
    input  logic [REG_ADDR_W-1:0]   rd_i,
    input  logic [DATA_W-1:0]       alu_result_i,
    input  logic [2*DATA_W-1:0]     mul_result_i,
    input  logic [DATA_W-1:0]       res2_i,
    input  logic                    mul_done_i,
    output logic                    mul_start_o,
    output logic                    reg_we_o,
    output logic [REG_ADDR_W-1:0]   reg_waddr_o,
    output logic [DATA_W-1:0]       reg_wdata_o,
    output logic                    busy_o,
    output logic                    illegal_op_o,
    output logic                    timeout_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    wb_state_t               state_q, state_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]       hi_q, hi_d;
    logic                    we_q, we_d;
    logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    mul_start_q, mul_start_d;
    logic                    illegal_q, illegal_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_q, busy_d;
    logic                    cnt_load, cnt_inc, cnt_at_limit;

    mul_timeout_cnt #(
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .inc_i      (cnt_inc),
        .at_limit_o (cnt_at_limit)
    );

    // Next-state and next-output decode; outputs land one cycle later.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        hi_d        = hi_q;
        we_d        = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        mul_start_d = 1'b0;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (sel_i)
                        SEL_ADD, SEL_ALU1, SEL_ALU2, SEL_ALU3, SEL_ALU5: begin
                            we_d    = 1'b1;
                            waddr_d = rd_i;
                            wdata_d = alu_result_i;
                        end
                        SEL_RES2: begin
                            we_d    = 1'b1;
                            waddr_d = rd_i;
                            wdata_d = res2_i;
                        end
                        SEL_MUL: begin
                            rd_d        = rd_i;
                            mul_start_d = 1'b1;
                            cnt_load    = 1'b1;
                            state_d     = MUL_WAIT;
                        end
                        SEL_ILL: begin
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL_WAIT: begin
                if (mul_done_i) begin
                    we_d    = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = mul_result_i[DATA_W-1:0];
                    hi_d    = mul_result_i[PROD_W-1:DATA_W];
                    state_d = WB_LO;
                end else if (cnt_at_limit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WB_LO: begin
                we_d    = 1'b1;
                waddr_d = rd_q + REG_ADDR_W'(1);
                wdata_d = hi_q;
                state_d = WB_HI;
            end
            WB_HI: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            hi_q        <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            mul_start_q <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            hi_q        <= hi_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            mul_start_q <= mul_start_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_start_o  = mul_start_q;
    assign reg_we_o     = we_q;
    assign reg_waddr_o  = waddr_q;
    assign reg_wdata_o  = wdata_q;
    assign busy_o       = busy_q;
    assign illegal_op_o = illegal_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_writeback_ctrl_24b.sv
// Scoreboard bench for writeback_ctrl_24b: the driver predicts every output event
// (kind, address, data, cycle) from the latency rules; a negedge monitor checks them.
module tb_writeback_ctrl_24b;
    import cpu_wb_pkg::*;

    localparam int TMO = 15;
    localparam int EV_MS  = 0;
    localparam int EV_WR  = 1;
    localparam int EV_ILL = 2;
    localparam int EV_TMO = 3;

    typedef struct {
        int          kind;
        int unsigned addr;
        int unsigned data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  sel;
    logic [3:0]  rd;
    logic [23:0] alu_result;
    logic [47:0] mul_result;
    logic [23:0] res2;
    logic        mul_done;
    logic        mul_start_o, reg_we_o, busy_o, illegal_op_o, timeout_o;
    logic [3:0]  reg_waddr_o;
    logic [23:0] reg_wdata_o;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];

    writeback_ctrl_24b #(
        .DATA_W      (24),
        .REG_ADDR_W  (4),
        .MUL_TIMEOUT (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .sel_i        (sel),
        .rd_i         (rd),
        .alu_result_i (alu_result),
        .mul_result_i (mul_result),
        .res2_i       (res2),
        .mul_done_i   (mul_done),
        .mul_start_o  (mul_start_o),
        .reg_we_o     (reg_we_o),
        .reg_waddr_o  (reg_waddr_o),
        .reg_wdata_o  (reg_wdata_o),
        .busy_o       (busy_o),
        .illegal_op_o (illegal_op_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int unsigned addr, input int unsigned data, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every asserted event output must match the oldest prediction.
    task automatic observe(input int kind, input int unsigned addr, input int unsigned data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h cycle=%0d, required none",
                     kind, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data || e.cyc != cyc) begin
                bad++;
                $display("FAIL event kind=%0d addr=%0h data=%0h cycle=%0d, required kind=%0d addr=%0h data=%0h cycle=%0d",
                         kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_start_o)  observe(EV_MS, 0, 0);
            if (reg_we_o)     observe(EV_WR, 32'(reg_waddr_o), 32'(reg_wdata_o));
            if (illegal_op_o) observe(EV_ILL, 0, 0);
            if (timeout_o)    observe(EV_TMO, 0, 0);
        end
    end

    task automatic issue_single(input logic [2:0] s, input logic [3:0] r, input logic [23:0] a, input logic [23:0] b);
        start = 1'b1; sel = s; rd = r; alu_result = a; res2 = b;
        if (s == SEL_ILL)       push(EV_ILL, 0, 0, cyc + 1);
        else if (s == SEL_RES2) push(EV_WR, 32'(r), 32'(b), cyc + 1);
        else                    push(EV_WR, 32'(r), 32'(a), cyc + 1);
        step();
        start = 1'b0;
    endtask

    // Multiply whose product arrives k cycles after MulStart (1 <= k < TMO).
    task automatic run_mul(input logic [3:0] r, input logic [47:0] prod, input int k, input bit noise);
        int t;
        t = cyc;
        start = 1'b1; sel = SEL_MUL; rd = r;
        push(EV_MS, 0, 0, t + 1);
        step();
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            chk("mul_wait_busy", 64'(busy_o), 1);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                sel = 3'($urandom); rd = 4'($urandom);
                alu_result = 24'($urandom); res2 = 24'($urandom);
            end
            step();
        end
        start = 1'b0;
        mul_done = 1'b1; mul_result = prod;
        push(EV_WR, 32'(r), 32'(prod % (48'd1 << 24)), cyc + 1);
        push(EV_WR, (32'(r) + 1) % 16, 32'(prod / (48'd1 << 24)), cyc + 2);
        step();
        mul_done = 1'b0; mul_result = 48'($urandom);
        chk("wb_lo_busy", 64'(busy_o), 1);
        step();
        chk("wb_hi_busy", 64'(busy_o), 1);
        step();
        chk("after_mul_busy", 64'(busy_o), 0);
    endtask

    task automatic run_timeout(input logic [3:0] r);
        int t;
        t = cyc;
        start = 1'b1; sel = SEL_MUL; rd = r;
        push(EV_MS, 0, 0, t + 1);
        push(EV_TMO, 0, 0, t + 1 + TMO);
        step();
        start = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_wait_busy", 64'(busy_o), 1);
            step();
        end
        chk("tmo_busy_drop", 64'(busy_o), 0);
        mul_done = 1'b1; mul_result = 48'h0BAD0BAD0BAD;
        step();
        mul_done = 1'b0;
        step();
        step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mul_start"}, 64'(mul_start_o), 0);
        chk({tag, "_we"}, 64'(reg_we_o), 0);
        chk({tag, "_waddr"}, 64'(reg_waddr_o), 0);
        chk({tag, "_wdata"}, 64'(reg_wdata_o), 0);
        chk({tag, "_busy"}, 64'(busy_o), 0);
        chk({tag, "_illegal"}, 64'(illegal_op_o), 0);
        chk({tag, "_timeout"}, 64'(timeout_o), 0);
    endtask

    initial begin
        logic [2:0] alu_sels [5];
        int op;
        alu_sels[0] = SEL_ADD; alu_sels[1] = SEL_ALU1; alu_sels[2] = SEL_ALU2;
        alu_sels[3] = SEL_ALU3; alu_sels[4] = SEL_ALU5;

        rst_n = 1'b0; start = 1'b0; sel = '0; rd = '0;
        alu_result = '0; mul_result = '0; res2 = '0; mul_done = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // ALU back-to-back
        issue_single(SEL_ADD, 4'd1, 24'h000011, 24'h0);
        chk("b2b_busy1", 64'(busy_o), 0);
        issue_single(SEL_ADD, 4'd2, 24'h000022, 24'h0);
        chk("b2b_busy2", 64'(busy_o), 0);
        issue_single(SEL_ADD, 4'd3, 24'h000033, 24'h0);
        chk("b2b_busy3", 64'(busy_o), 0);
        step();

        run_mul(4'd5, 48'h123456_ABCDEF, 4, 1'b1);
        run_mul(4'd15, 48'hFFFFFF_000001, 2, 1'b0);
        run_timeout(4'd9);

        issue_single(SEL_ILL, 4'd3, 24'h111111, 24'h0);
        issue_single(SEL_RES2, 4'd7, 24'h222222, 24'hCAFE01);
        step();

        // Reset in the middle of a multiply wait: nothing of it may surface later.
        start = 1'b1; sel = SEL_MUL; rd = 4'd4;
        push(EV_MS, 0, 0, cyc + 1);
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midmul_reset");
        step();
        rst_n = 1'b1;
        step();
        mul_done = 1'b1; mul_result = 48'hDEAD00_BEEF00;
        step();
        mul_done = 1'b0;
        step();
        check_all_zero("post_reset");

        // Randomized mix of issues
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4)
                issue_single(alu_sels[$urandom_range(0, 4)], 4'($urandom), 24'($urandom), 24'($urandom));
            else if (op == 5)
                issue_single(SEL_RES2, 4'($urandom), 24'($urandom), 24'($urandom));
            else if (op == 6)
                issue_single(SEL_ILL, 4'($urandom), 24'($urandom), 24'($urandom));
            else
                run_mul(4'($urandom), {24'($urandom), 24'($urandom)}, int'($urandom_range(1, TMO - 1)), 1'($urandom));
        end
        run_timeout(4'($urandom));

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
